// File: rtl/imm_encode_pipe_pkg.sv
// rtl/imm_encode_pipe_pkg.sv - RV32 immediate format constants, range-check/extract/normalise helpers
package imm_fmt_pkg;

    localparam logic [2:0]  FMT_I     = 3'b000;
    localparam logic [2:0]  FMT_S     = 3'b001;
    localparam logic [2:0]  FMT_U     = 3'b010;
    localparam logic [2:0]  FMT_B     = 3'b011;
    localparam logic [2:0]  FMT_J     = 3'b100;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= FMT_J;
    endfunction

    // Sign-extension fits only when every bit above the field's sign bit matches it.
    function automatic logic imm_range_err(input logic [2:0] fmt, input logic [31:0] imm);
        logic err;
        err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_U:        err = |imm[11:0];
            FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:      err = 1'b0;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] imm_extract(input logic [2:0] fmt, input logic [31:0] instr);
        logic [31:0] imm;
        imm = 32'd0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_U:   imm = {instr[31:12], 12'd0};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] imm_normalise(input logic [2:0] fmt, input logic [31:0] imm);
        logic [31:0] norm;
        norm = 32'd0;
        case (fmt)
            FMT_I, FMT_S: norm = {{20{imm[11]}}, imm[11:0]};
            FMT_U:        norm = {imm[31:12], 12'd0};
            FMT_B:        norm = {{19{imm[12]}}, imm[12:1], 1'b0};
            FMT_J:        norm = {{11{imm[20]}}, imm[20:1], 1'b0};
            default:      norm = 32'd0;
        endcase
        return norm;
    endfunction

endpackage

// File: rtl/imm_encode_pipe_if.sv
// rtl/imm_encode_pipe_if.sv - request/response bus of the immediate encoder (option: IMM_ROUNDTRIP_CHECK_EN)
interface imm_encode_pipe_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           imm_fmt;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [6:0]           funct7;
    logic [31:0]          imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          instr;
    logic                 imm_err;
    logic                 fmt_err;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic                 rt_mismatch;
`endif

    modport master (
`ifdef IMM_ROUNDTRIP_CHECK_EN
        input  rt_mismatch,
`endif
        output in_valid, imm_fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
        input  in_ready, out_valid, instr, imm_err, fmt_err, err_count
    );

    modport slave (
`ifdef IMM_ROUNDTRIP_CHECK_EN
        output rt_mismatch,
`endif
        input  in_valid, imm_fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
        output in_ready, out_valid, instr, imm_err, fmt_err, err_count
    );
endinterface

// File: rtl/imm_encode_pipe_scatter.sv
// rtl/imm_encode_pipe_scatter.sv - immediate bit scatter into an instruction overlay mask/value, plus range check
module imm_scatter
    import imm_fmt_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] mask,
    output logic [31:0] value,
    output logic        range_err
);

    always_comb begin
        mask  = 32'd0;
        value = 32'd0;
        case (fmt)
            FMT_I: begin
                mask  = 32'hFFF0_0000;
                value = {imm[11:0], 20'd0};
            end
            FMT_S: begin
                mask  = 32'hFE00_0F80;
                value = {imm[11:5], 13'd0, imm[4:0], 7'd0};
            end
            FMT_U: begin
                mask  = 32'hFFFF_F000;
                value = {imm[31:12], 12'd0};
            end
            FMT_B: begin
                mask  = 32'hFE00_0F80;
                value = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
            end
            FMT_J: begin
                mask  = 32'hFFFF_F000;
                value = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
            end
            default: begin
                mask  = 32'd0;
                value = 32'd0;
            end
        endcase
    end

    assign range_err = imm_range_err(fmt, imm);

endmodule

// File: rtl/imm_encode_pipe.sv
// rtl/imm_encode_pipe.sv - RV32 instruction encoder, two-stage valid/ready pipeline (option: IMM_ROUNDTRIP_CHECK_EN)
module imm_encode_pipe
    import imm_fmt_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input logic              clk,
    input logic              resetn,
    imm_encode_pipe_if.slave bus
);

    logic                 s1_valid, s2_valid;
    logic                 s1_ready, s2_ready;
    logic [31:0]          s1_instr, s2_instr;
    logic                 s1_imm_err, s2_imm_err;
    logic                 s1_fmt_err, s2_fmt_err;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [31:0] imm_mask, imm_value, base_word, enc_word;
    logic        range_err, fmt_bad;

    assign s2_ready     = !s2_valid || bus.out_ready;
    assign s1_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;

    imm_scatter u_scatter (
        .fmt       (bus.imm_fmt),
        .imm       (bus.imm),
        .mask      (imm_mask),
        .value     (imm_value),
        .range_err (range_err)
    );

    // Every field a format ignores (funct7 always) sits under that format's immediate mask.
    assign base_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
    assign fmt_bad   = !fmt_legal(bus.imm_fmt);
    assign enc_word  = fmt_bad ? NOP_INSTR : ((base_word & ~imm_mask) | imm_value);

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic [2:0]  s1_fmt;
    logic [31:0] s1_norm;
    logic        rt_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_instr   <= 32'd0;
            s1_imm_err <= 1'b0;
            s1_fmt_err <= 1'b0;
`ifdef IMM_ROUNDTRIP_CHECK_EN
            s1_fmt     <= 3'd0;
            s1_norm    <= 32'd0;
`endif
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_instr   <= enc_word;
                s1_imm_err <= range_err && !fmt_bad;
                s1_fmt_err <= fmt_bad;
`ifdef IMM_ROUNDTRIP_CHECK_EN
                s1_fmt     <= bus.imm_fmt;
                s1_norm    <= imm_normalise(bus.imm_fmt, bus.imm);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s2_valid   <= 1'b0;
            s2_instr   <= 32'd0;
            s2_imm_err <= 1'b0;
            s2_fmt_err <= 1'b0;
`ifdef IMM_ROUNDTRIP_CHECK_EN
            rt_q       <= 1'b0;
`endif
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr   <= s1_instr;
                s2_imm_err <= s1_imm_err;
                s2_fmt_err <= s1_fmt_err;
`ifdef IMM_ROUNDTRIP_CHECK_EN
                rt_q       <= !s1_imm_err && !s1_fmt_err &&
                              (imm_extract(s1_fmt, s1_instr) != s1_norm);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else if (s2_valid && bus.out_ready && (s2_imm_err || s2_fmt_err) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.instr     = s2_instr;
    assign bus.imm_err   = s2_imm_err;
    assign bus.fmt_err   = s2_fmt_err;
    assign bus.err_count = err_cnt_q;
`ifdef IMM_ROUNDTRIP_CHECK_EN
    assign bus.rt_mismatch = s2_valid && rt_q;
`endif

endmodule

// File: tb/tb_imm_encode_pipe.sv
// tb/tb_imm_encode_pipe.sv - directed vector bench for imm_encode_pipe (option: IMM_ROUNDTRIP_CHECK_EN)
module tb_imm_encode_pipe;
    import imm_fmt_pkg::*;

    localparam int ERR_CNT_W = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    imm_encode_pipe_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

    imm_encode_pipe #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_ierr;
        logic        exp_ferr;
    } vec_t;

    vec_t        vecs[18];
    int          checks    = 0;
    int          failures  = 0;
    int          exp_errs  = 0;
    logic [31:0] stream_exp[8];

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] ex, input logic ie,
                                input logic fe);
        vec_t v;
        v.fmt = fmt; v.opcode = op; v.rd = rd; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.exp_instr = ex; v.exp_ierr = ie; v.exp_ferr = fe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        bus.imm_fmt = v.fmt;
        bus.opcode  = v.opcode;
        bus.rd      = v.rd;
        bus.funct3  = v.f3;
        bus.rs1     = v.rs1;
        bus.rs2     = v.rs2;
        bus.funct7  = 7'h55;
        bus.imm     = v.imm;
    endtask

    // Returns just after the accepting rising edge.
    task automatic push(input vec_t v);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        #1;
        set_inputs(v);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        #1;
        bus.in_valid = 1'b0;
        check("push_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_out(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  got;
        int  sent;
        vec_t v;

        vecs[0]  = mk(FMT_I, 7'h13, 5'd1,  3'd0, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b0);
        vecs[1]  = mk(FMT_B, 7'h63, 5'd31, 3'd0, 5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0, 1'b0);
        vecs[2]  = mk(FMT_B, 7'h63, 5'd31, 3'd0, 5'd1,  5'd2,  32'h0000_0003, 32'h0020_8163, 1'b1, 1'b0);
        vecs[3]  = mk(FMT_J, 7'h6F, 5'd1,  3'd7, 5'd31, 5'd31, 32'h0010_0000, 32'h8000_00EF, 1'b1, 1'b0);
        vecs[4]  = mk(3'b111, 7'h33, 5'd1, 3'd0, 5'd2,  5'd3,  32'h0000_0003, 32'h0000_0013, 1'b0, 1'b1);
        vecs[5]  = mk(FMT_S, 7'h23, 5'd31, 3'd2, 5'd2,  5'd5,  32'hFFFF_FFF8, 32'hFE51_2C23, 1'b0, 1'b0);
        vecs[6]  = mk(FMT_U, 7'h37, 5'd5,  3'd7, 5'd31, 5'd31, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0);
        vecs[7]  = mk(FMT_U, 7'h37, 5'd5,  3'd0, 5'd0,  5'd0,  32'h1234_5001, 32'h1234_52B7, 1'b1, 1'b0);
        vecs[8]  = mk(FMT_I, 7'h13, 5'd0,  3'd0, 5'd0,  5'd31, 32'h0000_0800, 32'h8000_0013, 1'b1, 1'b0);
        vecs[9]  = mk(FMT_I, 7'h13, 5'd2,  3'd0, 5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0113, 1'b0, 1'b0);
        vecs[10] = mk(FMT_J, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0, 1'b0);
        vecs[11] = mk(FMT_J, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  32'hFFF0_0000, 32'h8000_006F, 1'b0, 1'b0);
        vecs[12] = mk(FMT_J, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  32'h0000_0001, 32'h0000_006F, 1'b1, 1'b0);
        vecs[13] = mk(FMT_B, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  32'h0000_0FFE, 32'h7E00_0FE3, 1'b0, 1'b0);
        vecs[14] = mk(FMT_B, 7'h63, 5'd0,  3'd0, 5'd0,  5'd0,  32'h0000_1000, 32'h8000_0063, 1'b1, 1'b0);
        vecs[15] = mk(3'b101, 7'h13, 5'd1, 3'd0, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0013, 1'b0, 1'b1);
        vecs[16] = mk(FMT_I, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  32'h0000_07FF, 32'h7FF0_0013, 1'b0, 1'b0);
        vecs[17] = mk(FMT_I, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  32'hFFFF_F7FF, 32'h7FF0_0013, 1'b1, 1'b0);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_inputs(vecs[0]);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_imm_err", {31'd0, bus.imm_err}, 32'd0);
        check("rst_fmt_err", {31'd0, bus.fmt_err}, 32'd0);
        check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            push(vecs[i]);
            wait_out(lat, got);
            check($sformatf("v%0d_got", i), {31'd0, got}, 32'd1);
            if (got) begin
                check($sformatf("v%0d_latency", i), lat, 2);
                check($sformatf("v%0d_instr", i), bus.instr, vecs[i].exp_instr);
                check($sformatf("v%0d_imm_err", i), {31'd0, bus.imm_err}, {31'd0, vecs[i].exp_ierr});
                check($sformatf("v%0d_fmt_err", i), {31'd0, bus.fmt_err}, {31'd0, vecs[i].exp_ferr});
`ifdef IMM_ROUNDTRIP_CHECK_EN
                check($sformatf("v%0d_rt", i), {31'd0, bus.rt_mismatch}, 32'd0);
`endif
                if (vecs[i].exp_ierr || vecs[i].exp_ferr) exp_errs++;
                @(negedge clk);
                check($sformatf("v%0d_err_count", i), {24'd0, bus.err_count}, exp_errs);
                check($sformatf("v%0d_drained", i), {31'd0, bus.out_valid}, 32'd0);
            end
        end

        // Stream under a 1010 output-ready pattern.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] sim;
            sim = k * 100 - 300;
            stream_exp[k] = {sim[11:0], 5'd0, 3'd0, 5'(k + 3), 7'h13};
        end
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [31:0] sim;
                    sim = k * 100 - 300;
                    v = mk(FMT_I, 7'h13, 5'(k + 3), 3'd0, 5'd0, 5'd0, sim, 32'd0, 1'b0, 1'b0);
                    push(v);
                end
            end
            begin
                int          taken;
                bit          stalled;
                logic [31:0] held;
                taken   = 0;
                stalled = 1'b0;
                held    = 32'd0;
                for (int cyc = 0; cyc < 200 && taken < 8; cyc++) begin
                    @(negedge clk);
                    bus.out_ready = (cyc[0] == 1'b0);
                    if (stalled && bus.out_valid) check("stall_hold", bus.instr, held);
                    if (bus.out_valid) begin
                        if (bus.out_ready) begin
                            check($sformatf("stream_w%0d", taken), bus.instr, stream_exp[taken]);
                            taken++;
                            stalled = 1'b0;
                        end else begin
                            stalled = 1'b1;
                            held    = bus.instr;
                        end
                    end else begin
                        stalled = 1'b0;
                    end
                end
                check("stream_count", taken, 8);
            end
        join
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("stream_no_dup", {31'd0, bus.out_valid}, 32'd0);

`ifdef IMM_ROUNDTRIP_CHECK_EN
        for (int n = 0; n < 40; n++) begin
            logic [31:0] r;
            logic [31:0] li;
            logic [2:0]  f;
            r = $urandom;
            f = 3'($urandom_range(0, 4));
            case (f)
                FMT_I, FMT_S: li = {{20{r[11]}}, r[11:0]};
                FMT_U:        li = {r[31:12], 12'd0};
                FMT_B:        li = {{19{r[12]}}, r[12:1], 1'b0};
                default:      li = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            v = mk(f, 7'h13, 5'(r[4:0]), 3'(r[7:5]), 5'(r[12:8]), 5'(r[17:13]), li, 32'd0, 1'b0, 1'b0);
            push(v);
            wait_out(lat, got);
            check("rt_got", {31'd0, got}, 32'd1);
            if (got) begin
                check("rt_mismatch", {31'd0, bus.rt_mismatch}, 32'd0);
                check("rt_imm_err", {31'd0, bus.imm_err}, 32'd0);
            end
            @(negedge clk);
        end
`endif

        // Saturate the error counter with back-to-back illegal formats.
        @(negedge clk);
        #1;
        v = mk(3'b111, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_inputs(v);
        bus.in_valid = 1'b1;
        sent = 0;
        for (int c = 0; c < 1000 && sent < (2 ** ERR_CNT_W) + 3; c++) begin
            if (bus.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("sat_sent", sent, (2 ** ERR_CNT_W) + 3);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("sat_drained", {31'd0, got}, 32'd1);
        check("sat_err_count", {24'd0, bus.err_count}, 32'd255);

        // Reset in the middle of a stream.
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.out_valid}, 32'd1);
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_err_count", {24'd0, bus.err_count}, 32'd0);
        check("mid_rst_instr", bus.instr, 32'd0);
        check("mid_rst_fmt_err", {31'd0, bus.fmt_err}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("post_rst_dropped", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
